// File: rtl/wave_addr_reader.sv
// Read-side sequencer for the waveform ROM bank: phase-accumulator address, latency-matched tag line and sample select.
// Optional macro AMP_SCALE_EN adds a 4-bit amplitude port and scales the sample in the output register stage.
module wave_addr_reader #(
    parameter int PHASE_W = 32,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 12,
    parameter int RD_LAT  = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [PHASE_W-1:0] ftw,
    input  logic [1:0]         wave_sel,
`ifdef AMP_SCALE_EN
    input  logic [3:0]         amp,
`endif
    output logic [ADDR_W-1:0]  addr,
    input  logic [DATA_W-1:0]  dout_sin,
    input  logic [DATA_W-1:0]  dout_sq,
    input  logic [DATA_W-1:0]  dout_tri,
    output logic [DATA_W-1:0]  sample,
    output logic               sample_vld,
    output logic               wrap,
    output logic               busy
);

    localparam logic [DATA_W-1:0] MID = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    typedef struct packed {
        logic       vld;
        logic [1:0] sel;
`ifdef AMP_SCALE_EN
        logic [3:0] amp;
`endif
    } tag_t;

    state_t             state;
    logic [PHASE_W-1:0] phase;
    logic [PHASE_W-1:0] ftw_q;
    logic [PHASE_W-1:0] inc;
    logic [PHASE_W-1:0] sum;
    logic               carry;
    logic [2:0]         drain_cnt;
    tag_t               tag_q [RD_LAT+1];
    tag_t               tag_new;
    logic [DATA_W-1:0]  raw;
    logic [DATA_W-1:0]  result;

    // The increment switches to the new tuning word on the wrap cycle itself, so a new
    // frequency starts exactly at the period boundary.
    always_comb begin
        inc            = wrap ? ftw : ftw_q;
        {carry, sum}   = {1'b0, phase} + {1'b0, inc};
        tag_new.vld    = 1'b1;
        tag_new.sel    = wave_sel;
`ifdef AMP_SCALE_EN
        tag_new.amp    = amp;
`endif
    end

    always_comb begin
        // NOTE: every variable in a combinational block gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        raw = MID;
        unique case (tag_q[RD_LAT].sel)
            2'd0:    raw = dout_sin;
            2'd1:    raw = dout_sq;
            2'd2:    raw = dout_tri;
            default: raw = MID;
        endcase
    end

`ifdef AMP_SCALE_EN
    localparam int MW = DATA_W + 5;
    logic signed [MW-1:0] diff;
    logic signed [MW-1:0] prod;

    always_comb begin
        diff   = $signed(MW'(raw)) - $signed(MW'(MID));
        prod   = diff * $signed(MW'({1'b0, tag_q[RD_LAT].amp} + 5'd1));
        result = DATA_W'($signed(MW'(MID)) + (prod >>> 4));
    end
`else
    assign result = raw;
`endif

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            phase      <= '0;
            ftw_q      <= '0;
            addr       <= '0;
            wrap       <= 1'b0;
            drain_cnt  <= '0;
            sample     <= MID;
            sample_vld <= 1'b0;
            // NOTE: the tag line is a few flops rather than a RAM, so it is cleared on
            // reset; that is what discards in-flight samples.
            for (int i = 0; i <= RD_LAT; i++) tag_q[i] <= '0;
        end else begin
            // NOTE: all state updates are non-blocking, so every register samples pre-edge
            // values regardless of statement order below.
            wrap     <= 1'b0;
            tag_q[0] <= '0;
            for (int i = 1; i <= RD_LAT; i++) tag_q[i] <= tag_q[i-1];

            unique case (state)
                IDLE: begin
                    phase <= '0;
                    addr  <= '0;
                    ftw_q <= ftw;
                    if (en) state <= RUN;
                end
                RUN: begin
                    if (en) begin
                        phase    <= sum;
                        addr     <= sum[PHASE_W-1 -: ADDR_W];
                        wrap     <= carry;
                        ftw_q    <= inc;
                        tag_q[0] <= tag_new;
                    end else begin
                        state     <= DRAIN;
                        drain_cnt <= '0;
                    end
                end
                DRAIN: begin
                    // The last tag leaves the line RD_LAT cycles after RUN exits.
                    if (drain_cnt == 3'(RD_LAT - 1)) begin
                        state <= IDLE;
                        phase <= '0;
                        addr  <= '0;
                    end else begin
                        drain_cnt <= drain_cnt + 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase

            sample_vld <= tag_q[RD_LAT].vld;
            if (tag_q[RD_LAT].vld) sample <= result;
        end
    end

endmodule

// File: doc/wave_addr_reader.md
Name: wave_addr_reader

Overview:
- Read-side sequencer for the waveform ROM bank (sin/square/tri, shared 16-bit address, 12-bit samples).
- A phase accumulator generates the shared ROM address.
- Tracks the ROM read latency, selects one of the three returned samples and presents it with a valid strobe to the DAC/display path.
- Sits between the control registers (frequency word, waveform select) and the ROM bank.

Parameters:
- PHASE_W, 32, phase accumulator width.
- ADDR_W, 16, ROM address width; addr = phase[PHASE_W-1 -: ADDR_W].
- DATA_W, 12, ROM sample width.
- RD_LAT, 1, ROM read latency in clk cycles (address registered to dout valid); legal 1..4.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  run request; level-sensitive
- ftw  in  PHASE_W  frequency tuning word (phase increment per clk)
- wave_sel  in  2  0=sin, 1=square, 2=tri, 3=midscale constant
- addr  out  ADDR_W  shared ROM address
- dout_sin  in  DATA_W  sin ROM data
- dout_sq  in  DATA_W  square ROM data
- dout_tri  in  DATA_W  tri ROM data
- sample  out  DATA_W  selected, registered sample
- sample_vld  out  1  sample valid strobe
- wrap  out  1  one-cycle pulse when the accumulator wraps past 2^PHASE_W
- busy  out  1  high in RUN or DRAIN

Behaviour:
- Reset (async, rst=1): state=IDLE; phase=0, ftw_q=0, addr=0, sample=2^(DATA_W-1) (12'h800), sample_vld=0, wrap=0, busy=0, valid/select pipelines cleared.
- States: IDLE, RUN, DRAIN.
  - IDLE: phase held at 0, addr=0; ftw_q<=ftw every cycle. en=1 -> RUN.
  - RUN: each cycle phase<=phase+ftw_q (mod 2^PHASE_W); addr<=next phase[MSBs]; a tag {vld=1, sel=wave_sel} enters the delay line. en=0 -> DRAIN (no new tag issued that cycle).
  - DRAIN: addr held, tags of 0 shifted in. After RUN exits, the delay line empties in RD_LAT+1 cycles -> IDLE, phase reset to 0. en=1 during DRAIN is ignored until IDLE is reached; IDLE then re-enters RUN on the following cycle.
- Frequency update: ftw_q reloads from ftw only in IDLE or on the cycle wrap is asserted, so frequency changes take effect at period boundaries (phase-continuous).
- wrap: asserted the cycle after the add carries out. Not asserted in IDLE/DRAIN.
- Latency: address issued at cycle t -> ROM data at t+RD_LAT -> sample/sample_vld registered at t+RD_LAT+1.
  - The sel tag travels with the address, so a wave_sel change never mixes waveforms within one sample.
  - Back-to-back: one sample per clk in RUN.
- Select: sel=3 outputs 12'h800 with sample_vld=1.
- sample holds its last value when sample_vld=0.
- busy = (state != IDLE).
- Reset asserted mid-RUN: immediate return to the reset values above; in-flight samples are discarded.
- ftw=0 in RUN: addr constant, samples still valid every cycle, no wrap.

Optional Feature:
- Macro AMP_SCALE_EN.
- Defined:
  - Adds port amp in 4.
  - Output becomes sample = 2048 + (((raw-2048) * (amp+1)) >>> 4), signed arithmetic, 17-bit intermediate, no saturation needed.
  - amp is sampled together with wave_sel into the tag; latency unchanged (scaling is done in the output register stage).
- Undefined: no amp port; sample = raw selected data.

Test Plan:
- Reset check: rst pulse mid-RUN with ftw=32'h0100_0000 -> next edge addr=0, sample=12'h800, sample_vld=0, busy=0, state IDLE.
- Sweep: en=1, ftw=32'h0100_0000, RD_LAT=1 ROM model.
  - addr steps 0x0100, 0x0200, ... every clk.
  - First sample_vld exactly 2 clks after first addr.
  - wrap pulses every 256 clks.
- Waveform switch: wave_sel changes 0->2 mid-stream -> samples taken from dout_sin until the first tagged-tri address, then from dout_tri, with no stray sample; sel=3 -> 12'h800.
- Frequency change: ftw changed to 32'h0200_0000 mid-period -> increment stays 0x0100 until the wrap pulse, then 0x0200.
- Drain: en dropped after 10 issued addresses with RD_LAT=3 -> exactly 10 sample_vld pulses total, busy low 4 clks after en low, phase=0.
- AMP_SCALE_EN: amp=7, raw=12'hFFF -> sample=2048+(2047*8>>>4)=3071; amp=15 -> sample=raw.
